fir_xifu_wb: RTL and testbench
==============================

Name: fir_xifu_wb

Overview:
Writeback stage of the FIR XIFU: the producer side of the wb2regfile interface into the XIFU register file.
- Holds one instruction from EX and waits for its CV-X-IF commit/kill.
- Drives exactly one result transaction back to the core for every committed, non-killed instruction.
- Pulses the single internal register-file write port on retirement.
- Sits between the EX stage and fir_xifu_regfile / the core X-IF result channel.

Parameters:
NB_IDS, 4, number of outstanding X-IF instruction IDs tracked; ID_W = $clog2(NB_IDS)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
ex_valid_i  in  1  EX has an instruction for WB
ex_ready_o  out  1  WB can accept this cycle
ex2wb_i  in  fir_xifu_ex2wb_t  {id[ID_W], rd[5], result[32], write_xrf, write_gpr}
commit_valid_i  in  1  X-IF commit strobe
commit_id_i  in  ID_W  committed/killed instruction ID
commit_kill_i  in  1  1 = kill, 0 = commit
result_valid_o  out  1  X-IF result valid
result_ready_i  in  1  core accepts result
result_id_o  out  ID_W  result instruction ID
result_rd_o  out  5  core GPR destination
result_data_o  out  32  result value
result_we_o  out  1  core GPR write enable (= write_gpr)
wb2regfile_o  out  fir_xifu_wb2regfile_t  {write, rd[5], result[32]} to register file

Behaviour:
- Reset (async): FSM=IDLE; commit/kill bitmaps cleared; entry register cleared; all outputs 0, except ex_ready_o=1.
- Commit scoreboard: committed_q[NB_IDS] and killed_q[NB_IDS].
  - commit_valid_i sets committed_q[id]=1 and killed_q[id]=commit_kill_i.
  - Both bits for an id clear when that id retires.
  - Commit may arrive before, during, or after the entry is in WB.
- Commit forwarding: entry_committed = committed_q[entry.id] | (commit_valid_i & commit_id_i==entry.id). Killed is forwarded the same way.
- A commit arriving in the same cycle its id retires does not set the bits; the retire clear wins.
- FSM:
  - IDLE: ex_ready_o=1. On ex_valid_i, capture ex2wb_i -> PENDING.
  - PENDING: wait for entry_committed.
    - If killed: drop the entry (no write, no result) and retire this cycle.
    - Otherwise assert result_valid_o this same cycle -> RESP.
  - RESP: result_valid_o=1 with result_id_o/rd/data/we stable until result_ready_i. The handshake cycle is the retire.
  - PENDING with commit already available and result_ready_i=1: result handshake and retire in the same cycle.
- Retire cycle:
  - wb2regfile_o.write = entry.write_xrf & ~killed, as a single-cycle pulse.
  - wb2regfile_o.rd/result always driven from the entry register.
  - ex_ready_o=1; a new ex_valid_i is captured the same cycle (back-to-back, 1 instr/cycle when result_ready_i=1 and commits are early).
  - Next state is PENDING if a new entry is captured, else IDLE.
- ex_ready_o = (state==IDLE) | retire; combinational, no combinational path from ex_valid_i.
- result_valid_o must not drop before result_ready_i (X-IF rule).
- Killed entries never raise result_valid_o.
- write_xrf=0, write_gpr=0: a result still issues with result_we_o=0.
- Latency: capture at edge N; earliest result/write in cycle N+1.
- Reset mid-RESP: transaction abandoned, result_valid_o=0 immediately.

Decomposition:
- fir_xifu_pkg gains:
  - fir_xifu_ex2wb_t;
  - reuse of the existing fir_xifu_wb2regfile_t;
  - localparam ID_W derived from NB_IDS;
  - a state enum typedef fir_xifu_wb_state_t {IDLE, PENDING, RESP}.
- One natural sub-module: fir_xifu_commit_tracker (commit/kill bitmaps, forwarding, clear-on-retire).

Test Plan:
- Commit before arrival: commit id=1 (kill=0); then ex id=1, rd=3, result=0xDEADBEEF, write_xrf=1, write_gpr=1, result_ready_i=1 -> next cycle result_valid_o=1 (id=1, rd=3, data=0xDEADBEEF, we=1) and wb2regfile write=1, rd=3 for one cycle; scoreboard bit 1 cleared.
- Commit after arrival: ex id=2, write_xrf=1; commit id=2 three cycles later -> wb2regfile write and result in that commit cycle, nothing earlier.
- Kill: ex id=0, write_xrf=1; commit_kill id=0 -> no result_valid_o, no write; ex_ready_o=1 that cycle.
- Back-pressure: result_ready_i=0 for 4 cycles -> result_valid_o and data stable; ex_ready_o=0; write fires only in the ready cycle.
- Back-to-back: ids 0,1,2,3 pre-committed, result_ready_i=1 -> one retire per cycle, 4 writes in 4 consecutive cycles, ex_ready_o constantly 1.
- Reset during RESP -> all outputs 0 asynchronously; commit bitmap cleared; a subsequent ex id=1 waits for a fresh commit.

Source files
------------

// File: rtl/fir_xifu_pkg.sv
// fir_xifu_pkg: shared types and constants for the FIR XIFU.
//   FIR_XIFU_NB_IDS / ID_W  : outstanding X-IF instruction IDs and ID width
//   fir_xifu_ex2wb_t        : EX -> WB instruction payload
//   fir_xifu_wb2regfile_t   : WB -> register file write port
//   fir_xifu_wb_state_t     : writeback FSM states
package fir_xifu_pkg;

    localparam int FIR_XIFU_NB_IDS = 4;
    localparam int ID_W            = $clog2(FIR_XIFU_NB_IDS);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [4:0]      rd;
        logic [31:0]     result;
        logic            write_xrf;
        logic            write_gpr;
    } fir_xifu_ex2wb_t;

    typedef struct packed {
        logic        write;
        logic [4:0]  rd;
        logic [31:0] result;
    } fir_xifu_wb2regfile_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        RESP    = 2'd2
    } fir_xifu_wb_state_t;

endpackage

// File: rtl/fir_xifu_wb_if.sv
// fir_xifu_wb_if: CV-X-IF commit and result channels seen by the WB stage.
//   commit_valid/commit_id/commit_kill : core -> WB commit strobe
//   result_valid/result_ready          : result handshake
//   result_id/result_rd/result_data/result_we : result payload (WB -> core)
// modport master: the WB stage (result producer); modport slave: the core.
interface fir_xifu_wb_if;
    import fir_xifu_pkg::*;

    logic            commit_valid;
    logic [ID_W-1:0] commit_id;
    logic            commit_kill;

    logic            result_valid;
    logic            result_ready;
    logic [ID_W-1:0] result_id;
    logic [4:0]      result_rd;
    logic [31:0]     result_data;
    logic            result_we;

    modport master (
        input  commit_valid, commit_id, commit_kill, result_ready,
        output result_valid, result_id, result_rd, result_data, result_we
    );

    modport slave (
        output commit_valid, commit_id, commit_kill, result_ready,
        input  result_valid, result_id, result_rd, result_data, result_we
    );

endinterface

// File: rtl/fir_xifu_commit_tracker.sv
// fir_xifu_commit_tracker: per-ID commit/kill scoreboard.
//   clk_i, rst_ni          : clock, async active-low reset
//   commit_valid/id/kill   : X-IF commit strobe
//   entry_id               : ID of the instruction currently held in WB
//   retire                 : WB entry retires this cycle (clears its bits)
//   entry_committed/killed : status of entry_id, including a same-cycle commit
module fir_xifu_commit_tracker
    import fir_xifu_pkg::*;
#(
    parameter int NB_IDS = FIR_XIFU_NB_IDS
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            commit_valid,
    input  logic [ID_W-1:0] commit_id,
    input  logic            commit_kill,
    input  logic [ID_W-1:0] entry_id,
    input  logic            retire,
    output logic            entry_committed,
    output logic            entry_killed
);

    logic [NB_IDS-1:0] committed_q;
    logic [NB_IDS-1:0] killed_q;
    logic              fwd_hit;

    // Retire clear has priority over a commit landing on the same id.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            committed_q <= '0;
            killed_q    <= '0;
        end else begin
            for (int i = 0; i < NB_IDS; i++) begin
                if (retire && (entry_id == ID_W'(i))) begin
                    committed_q[i] <= 1'b0;
                    killed_q[i]    <= 1'b0;
                end else if (commit_valid && (commit_id == ID_W'(i))) begin
                    committed_q[i] <= 1'b1;
                    killed_q[i]    <= commit_kill;
                end
            end
        end
    end

    // Forward a commit arriving this cycle so the entry can retire without
    // waiting for the bitmap to update.
    assign fwd_hit         = commit_valid && (commit_id == entry_id);
    assign entry_committed = committed_q[entry_id] | fwd_hit;
    assign entry_killed    = killed_q[entry_id] | (fwd_hit & commit_kill);

endmodule

// File: rtl/fir_xifu_wb.sv
// fir_xifu_wb: writeback stage of the FIR XIFU.
// Holds one EX instruction, waits for its X-IF commit/kill, returns one
// result per committed instruction and pulses the register-file write port
// on retirement.
//   clk_i, rst_ni  : clock, async active-low reset
//   ex_valid_i/ex_ready_o/ex2wb_i : EX -> WB handshake and payload
//   xif            : X-IF commit input and result output channel
//   wb2regfile_o   : single register-file write port
module fir_xifu_wb
    import fir_xifu_pkg::*;
#(
    parameter int NB_IDS = FIR_XIFU_NB_IDS
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  fir_xifu_ex2wb_t      ex2wb_i,
    fir_xifu_wb_if.master        xif,
    output fir_xifu_wb2regfile_t wb2regfile_o
);

    fir_xifu_wb_state_t state_q, state_d;
    fir_xifu_ex2wb_t    entry_q;

    logic entry_committed;
    logic entry_killed;
    logic retire;
    logic drop;
    logic result_valid;
    logic capture;

    fir_xifu_commit_tracker #(
        .NB_IDS(NB_IDS)
    ) u_tracker (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .commit_valid    (xif.commit_valid),
        .commit_id       (xif.commit_id),
        .commit_kill     (xif.commit_kill),
        .entry_id        (entry_q.id),
        .retire          (retire),
        .entry_committed (entry_committed),
        .entry_killed    (entry_killed)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ex_valid_i) state_d = PENDING;
            PENDING: if (entry_committed && !entry_killed && !xif.result_ready)
                         state_d = RESP;
            RESP:    ;
            default: state_d = IDLE;
        endcase
        // A retiring entry frees the slot for the instruction captured now.
        if (retire) state_d = ex_valid_i ? PENDING : IDLE;
    end

    always_comb begin
        result_valid = 1'b0;
        retire       = 1'b0;
        drop         = 1'b0;
        case (state_q)
            PENDING: begin
                if (entry_committed) begin
                    if (entry_killed) begin
                        retire = 1'b1;
                        drop   = 1'b1;
                    end else begin
                        result_valid = 1'b1;
                        retire       = xif.result_ready;
                    end
                end
            end
            RESP: begin
                result_valid = 1'b1;
                retire       = xif.result_ready;
            end
            default: ;
        endcase
        ex_ready_o          = (state_q == IDLE) | retire;
        capture             = ex_valid_i & ex_ready_o;
        wb2regfile_o.write  = retire & entry_q.write_xrf & ~drop;
        wb2regfile_o.rd     = entry_q.rd;
        wb2regfile_o.result = entry_q.result;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      entry_q <= '0;
        else if (capture) entry_q <= ex2wb_i;
    end

    assign xif.result_valid = result_valid;
    assign xif.result_id    = entry_q.id;
    assign xif.result_rd    = entry_q.rd;
    assign xif.result_data  = entry_q.result;
    assign xif.result_we    = entry_q.write_gpr;

endmodule

// File: tb/tb_fir_xifu_wb.sv
module tb_fir_xifu_wb;
    import fir_xifu_pkg::*;

    localparam int N_RAND = 300;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 ex_valid_i;
    logic                 ex_ready_o;
    fir_xifu_ex2wb_t      ex2wb_i;
    fir_xifu_wb2regfile_t wb2regfile_o;

    fir_xifu_wb_if xif();

    fir_xifu_wb #(.NB_IDS(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ex_valid_i   (ex_valid_i),
        .ex_ready_o   (ex_ready_o),
        .ex2wb_i      (ex2wb_i),
        .xif          (xif),
        .wb2regfile_o (wb2regfile_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: at most one held instruction; it may retire once its
    // id is committed (or a commit for it arrives now); a kill drops it, a
    // commit needs result_ready.
    bit              m_have;
    fir_xifu_ex2wb_t m_ent;
    bit              m_cm [4];
    bit              m_kl [4];
    int              m_issued = 0;
    int              m_retired = 0;
    bit              e_c, e_k, e_rv, e_ret, e_rdy, e_hit;
    int              e_id;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            chk("rst_ex_ready", ex_ready_o, 1);
            chk("rst_result_valid", xif.result_valid, 0);
            chk("rst_wb_write", wb2regfile_o.write, 0);
            chk("rst_wb_rd", wb2regfile_o.rd, 0);
            chk("rst_wb_result", wb2regfile_o.result, 0);
            m_have = 0;
            m_ent  = '0;
            for (int i = 0; i < 4; i++) begin m_cm[i] = 0; m_kl[i] = 0; end
        end else begin
            e_id  = int'(m_ent.id);
            e_hit = xif.commit_valid && (xif.commit_id == m_ent.id);
            e_c   = m_have && (m_cm[e_id] || e_hit);
            e_k   = m_have && (m_kl[e_id] || (e_hit && xif.commit_kill));
            e_rv  = e_c && !e_k;
            e_ret = e_c && (e_k || xif.result_ready);
            e_rdy = !m_have || e_ret;
            chk("ex_ready", ex_ready_o, e_rdy);
            chk("result_valid", xif.result_valid, e_rv);
            chk("wb_write", wb2regfile_o.write, e_ret && m_ent.write_xrf && !e_k);
            chk("wb_rd", wb2regfile_o.rd, m_ent.rd);
            chk("wb_result", wb2regfile_o.result, m_ent.result);
            if (e_rv) begin
                chk("result_id", xif.result_id, m_ent.id);
                chk("result_rd", xif.result_rd, m_ent.rd);
                chk("result_data", xif.result_data, m_ent.result);
                chk("result_we", xif.result_we, m_ent.write_gpr);
            end
            for (int i = 0; i < 4; i++) begin
                if (e_ret && i == e_id) begin
                    m_cm[i] = 0; m_kl[i] = 0;
                end else if (xif.commit_valid && int'(xif.commit_id) == i) begin
                    m_cm[i] = 1; m_kl[i] = xif.commit_kill;
                end
            end
            if (e_ret) m_retired++;
            if (ex_valid_i && e_rdy) begin
                m_have = 1; m_ent = ex2wb_i; m_issued++;
            end else if (e_ret) begin
                m_have = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_ex(input bit v, input int id, input int rd, input logic [31:0] res,
                          input bit wx, input bit wg);
        ex_valid_i       = v;
        ex2wb_i.id       = ID_W'(id);
        ex2wb_i.rd       = 5'(rd);
        ex2wb_i.result   = res;
        ex2wb_i.write_xrf = wx;
        ex2wb_i.write_gpr = wg;
    endtask

    task automatic set_commit(input bit v, input int id, input bit kill);
        xif.commit_valid = v;
        xif.commit_id    = ID_W'(id);
        xif.commit_kill  = kill;
    endtask

    logic [4:0]  r_rd  [N_RAND];
    logic [31:0] r_res [N_RAND];
    bit          r_wx  [N_RAND];
    bit          r_wg  [N_RAND];

    initial begin
        int base_i, base_r, cnext, cyc, iss, ret;
        set_ex(0, 0, 0, 0, 0, 0);
        set_commit(0, 0, 0);
        xif.result_ready = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_ready_lit", ex_ready_o, 1);
        chk("reset_valid_lit", xif.result_valid, 0);
        rst_ni = 1'b1;
        step();

        // Commit before arrival
        set_commit(1, 1, 0);
        step();
        set_commit(0, 0, 0);
        set_ex(1, 1, 3, 32'hDEADBEEF, 1, 1);
        xif.result_ready = 1'b1;
        @(negedge clk_i);
        chk("t1_pre_valid", xif.result_valid, 0);
        step();
        set_ex(0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("t1_valid", xif.result_valid, 1);
        chk("t1_id", xif.result_id, 1);
        chk("t1_rd", xif.result_rd, 3);
        chk("t1_data", xif.result_data, 32'hDEADBEEF);
        chk("t1_we", xif.result_we, 1);
        chk("t1_write", wb2regfile_o.write, 1);
        chk("t1_wb_rd", wb2regfile_o.rd, 3);
        step();
        @(negedge clk_i);
        chk("t1_write_pulse", wb2regfile_o.write, 0);
        chk("t1_valid_drop", xif.result_valid, 0);
        chk("t1_bit_clear", dut.u_tracker.committed_q[1], 0);
        step();

        // Commit after arrival
        set_ex(1, 2, 7, 32'hA5A50002, 1, 0);
        step();
        set_ex(0, 0, 0, 0, 0, 0);
        repeat (3) begin
            @(negedge clk_i);
            chk("t2_early_valid", xif.result_valid, 0);
            chk("t2_early_write", wb2regfile_o.write, 0);
            step();
        end
        set_commit(1, 2, 0);
        @(negedge clk_i);
        chk("t2_valid", xif.result_valid, 1);
        chk("t2_write", wb2regfile_o.write, 1);
        chk("t2_we", xif.result_we, 0);
        chk("t2_data", xif.result_data, 32'hA5A50002);
        step();
        set_commit(0, 0, 0);

        // Kill
        set_ex(1, 0, 9, 32'h00000009, 1, 1);
        step();
        set_ex(0, 0, 0, 0, 0, 0);
        set_commit(1, 0, 1);
        @(negedge clk_i);
        chk("t3_valid", xif.result_valid, 0);
        chk("t3_write", wb2regfile_o.write, 0);
        chk("t3_ready", ex_ready_o, 1);
        step();
        set_commit(0, 0, 0);

        // Back-pressure
        set_commit(1, 3, 0);
        step();
        set_commit(0, 0, 0);
        set_ex(1, 3, 12, 32'h12345678, 1, 1);
        xif.result_ready = 1'b0;
        step();
        set_ex(0, 0, 0, 0, 0, 0);
        repeat (4) begin
            @(negedge clk_i);
            chk("t4_valid", xif.result_valid, 1);
            chk("t4_data", xif.result_data, 32'h12345678);
            chk("t4_ready", ex_ready_o, 0);
            chk("t4_write", wb2regfile_o.write, 0);
            step();
        end
        xif.result_ready = 1'b1;
        @(negedge clk_i);
        chk("t4_write_rdy", wb2regfile_o.write, 1);
        chk("t4_ready_rdy", ex_ready_o, 1);
        step();

        // Back-to-back with pre-committed ids
        for (int i = 0; i < 4; i++) begin
            set_commit(1, i, 0);
            step();
        end
        set_commit(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) set_ex(1, i, i + 1, 32'h100 + 32'(i), 1, 1);
            else       set_ex(0, 0, 0, 0, 0, 0);
            @(negedge clk_i);
            chk("t5_ready", ex_ready_o, 1);
            if (i > 0) begin
                chk("t5_write", wb2regfile_o.write, 1);
                chk("t5_wb_rd", wb2regfile_o.rd, i);
            end
            step();
        end
        set_ex(0, 0, 0, 0, 0, 0);

        // Reset during RESP
        set_commit(1, 1, 0);
        step();
        set_commit(0, 0, 0);
        set_ex(1, 1, 5, 32'h0000CAFE, 1, 1);
        xif.result_ready = 1'b0;
        step();
        set_ex(0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("t6_valid_before", xif.result_valid, 1);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_valid_async", xif.result_valid, 0);
        chk("t6_write_async", wb2regfile_o.write, 0);
        chk("t6_ready_async", ex_ready_o, 1);
        chk("t6_bitmap", dut.u_tracker.committed_q, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        xif.result_ready = 1'b1;
        set_ex(1, 1, 5, 32'h0000BEEF, 1, 1);
        step();
        set_ex(0, 0, 0, 0, 0, 0);
        repeat (2) begin
            @(negedge clk_i);
            chk("t6_wait_commit", xif.result_valid, 0);
            step();
        end
        set_commit(1, 1, 0);
        @(negedge clk_i);
        chk("t6_valid_after", xif.result_valid, 1);
        chk("t6_write_after", wb2regfile_o.write, 1);
        step();
        set_commit(0, 0, 0);
        repeat (2) step();

        // Randomized traffic
        for (int k = 0; k < N_RAND; k++) begin
            r_rd[k]  = 5'($urandom);
            r_res[k] = $urandom;
            r_wx[k]  = 1'($urandom_range(0, 1));
            r_wg[k]  = 1'($urandom_range(0, 1));
        end
        base_i = m_issued;
        base_r = m_retired;
        cnext  = 0;
        cyc    = 0;
        while ((m_retired - base_r) < N_RAND && cyc < 20000) begin
            iss = m_issued - base_i;
            ret = m_retired - base_r;
            if (iss < N_RAND && $urandom_range(0, 9) < 7)
                set_ex(1, iss % 4, int'(r_rd[iss]), r_res[iss], r_wx[iss], r_wg[iss]);
            else
                set_ex(0, 0, 0, 0, 0, 0);
            if (cnext < N_RAND && cnext <= iss && cnext < ret + 4 && $urandom_range(0, 9) < 5) begin
                set_commit(1, cnext % 4, $urandom_range(0, 3) == 0);
                cnext++;
            end else begin
                set_commit(0, 0, 0);
            end
            xif.result_ready = $urandom_range(0, 9) < 6;
            step();
            cyc++;
        end
        chk("rand_all_retired", 64'(m_retired - base_r), 64'(N_RAND));
        set_ex(0, 0, 0, 0, 0, 0);
        set_commit(0, 0, 0);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
